fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch front end with a 2-entry decode FIFO.
// Issues sequential fetches, tags returned words with their PC, and handles
// branch/jump redirects by flushing the FIFO and draining stale responses.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   imem_req_*        fetch request (valid/ready handshake, address)
//   imem_resp_*       in-order returned instruction words
//   redirect_*        redirect request and target PC
//   inst_valid/ready  decode handshake; instruction/inst_pc = FIFO head
//   fetch_misalign    sticky misaligned-redirect flag, present only when
//                     FETCH_MISALIGN_CHECK_EN is defined
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(32'h0000_0000)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_resp_valid,
    input  logic [31:0]           imem_resp_data,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [31:0]           instruction,
    output logic [DATA_WIDTH-1:0] inst_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic                  fetch_misalign
`endif
);

    typedef enum logic {
        FETCH,
        DRAIN
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] pc;
    logic [1:0]            outstanding;
    logic [1:0]            count;
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [31:0]           fifo_inst [2];
    logic [DATA_WIDTH-1:0] fifo_pc   [2];

    logic                  blocked;
    logic [DATA_WIDTH-1:0] target;
    logic                  req_fire;
    logic                  resp_take;
    logic                  push;
    logic                  pop;
    logic [1:0]            out_next;
    logic [DATA_WIDTH-1:0] resp_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end

    assign fetch_misalign = misalign_q;
    assign blocked        = misalign_q;
    assign target         = redirect_pc;
`else
    assign blocked = 1'b0;
    assign target  = redirect_pc & ~{{(DATA_WIDTH-2){1'b0}}, 2'b11};
`endif

    // Outstanding requests plus buffered words never exceed the FIFO depth,
    // so every live response is guaranteed a free slot.
    assign imem_req_valid = (state == FETCH) && !blocked &&
                            (({1'b0, outstanding} + {1'b0, count}) < 3'd2);
    assign imem_req_addr  = pc;

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign resp_take = imem_resp_valid && (outstanding != 2'd0);
    assign push      = resp_take && (state == FETCH) && !redirect_valid;
    assign pop       = inst_valid && inst_ready && !redirect_valid;
    assign out_next  = outstanding + 2'(req_fire) - 2'(resp_take);

    // In FETCH the in-flight requests are consecutive words ending at pc-4,
    // so the oldest one sits outstanding words behind the fetch PC.
    assign resp_pc = pc - {{(DATA_WIDTH-4){1'b0}}, outstanding, 2'b00};

    assign inst_valid  = (count != 2'd0);
    assign instruction = fifo_inst[rd_ptr];
    assign inst_pc     = fifo_pc[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            outstanding  <= 2'd0;
            count        <= 2'd0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            fifo_inst[0] <= '0;
            fifo_inst[1] <= '0;
            fifo_pc[0]   <= '0;
            fifo_pc[1]   <= '0;
        end else begin
            outstanding <= out_next;
            if (redirect_valid) begin
                // Everything still in flight now belongs to the old path.
                pc     <= target;
                count  <= 2'd0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
                state  <= (out_next != 2'd0) ? DRAIN : FETCH;
            end else begin
                if (req_fire) begin
                    pc <= pc + DATA_WIDTH'(4);
                end
                if (push) begin
                    fifo_inst[wr_ptr] <= imem_resp_data;
                    fifo_pc[wr_ptr]   <= resp_pc;
                    wr_ptr            <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                count <= count + 2'(push) - 2'(pop);
                case (state)
                    FETCH:   state <= FETCH;
                    DRAIN:   if (out_next == 2'd0) state <= FETCH;
                    default: state <= FETCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// Memory model answers accepted requests in order with 1-cycle latency.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    int          n_acc = 0;
    bit          auto_resp = 0;
    logic [31:0] pend [$];

    fetch_unit #(
        .DATA_WIDTH(32),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .instruction    (instruction),
        .inst_pc        (inst_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .fetch_misalign (fetch_misalign)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], 16'h0013};
    endfunction

    // One clock cycle, entered and left at a negedge.
    task automatic tick();
        logic        acc;
        logic        rv;
        logic [31:0] a;
        logic [31:0] junk;
        if (auto_resp) begin
            if (pend.size() > 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(pend[0]);
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = 32'h0;
            end
        end
        #1;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        rv  = imem_resp_valid;
        @(posedge clk);
        if (rv && pend.size() > 0) junk = pend.pop_front();
        if (acc) begin
            pend.push_back(a);
            n_acc++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        inst_ready      = 1'b0;
        auto_resp       = 1'b0;
        pend.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        inst_ready      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_inst_valid: got %b want 0", inst_valid);
        end
        n_checks++;
        if (instruction !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_instruction: got %h want 0", instruction);
        end
        n_checks++;
        if (inst_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_inst_pc: got %h want 0", inst_pc);
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        n_checks++;
        if (fetch_misalign !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_misalign: got %b want 0", fetch_misalign);
        end
`endif
        rst = 1'b0;
        #1;
        n_checks++;
        if (imem_req_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL first_req_valid: got %b want 1", imem_req_valid);
        end
        n_checks++;
        if (imem_req_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL first_req_addr: got %h want 0", imem_req_addr);
        end
    endtask

    task automatic test_sequential();
        int got;
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        auto_resp      = 1'b1;
        got = 0;
        for (int c = 0; c < 30 && got < 3; c++) begin
            if (inst_valid) begin
                n_checks++;
                if (inst_pc !== 32'(got * 4)) begin
                    n_fail++;
                    $display("FAIL seq_pc%0d: got %h want %h",
                             got, inst_pc, 32'(got * 4));
                end
                n_checks++;
                if (instruction !== mem_word(32'(got * 4))) begin
                    n_fail++;
                    $display("FAIL seq_inst%0d: got %h want %h",
                             got, instruction, mem_word(32'(got * 4)));
                end
                got++;
            end
            tick();
        end
        n_checks++;
        if (got !== 3) begin
            n_fail++;
            $display("FAIL seq_timeout: got %0d words want 3", got);
        end
    endtask

    task automatic test_backpressure();
        int acc0;
        do_reset();
        imem_req_ready = 1'b1;
        auto_resp      = 1'b1;
        acc0 = n_acc;
        for (int c = 0; c < 10; c++) tick();
        n_checks++;
        if (n_acc - acc0 !== 2) begin
            n_fail++;
            $display("FAIL bp_requests: got %0d want 2", n_acc - acc0);
        end
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_req_valid_full: got %b want 0", imem_req_valid);
        end
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=0",
                     inst_valid, inst_pc);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin
            n_fail++;
            $display("FAIL bp_after_pop_req: got v=%b a=%h want v=1 a=8",
                     imem_req_valid, imem_req_addr);
        end
        n_checks++;
        if (inst_pc !== 32'h4) begin
            n_fail++;
            $display("FAIL bp_after_pop_head: got %h want 4", inst_pc);
        end
    endtask

    task automatic test_redirect_drain();
        int drain;
        int got;
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        tick();
        tick();
        n_checks++;
        if (imem_req_valid !== 1'b0 || pend.size() != 2) begin
            n_fail++;
            $display("FAIL drain_setup: got v=%b pend=%0d want v=0 pend=2",
                     imem_req_valid, pend.size());
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_no_req: got %b want 0", imem_req_valid);
        end
        auto_resp = 1'b1;
        drain = 0;
        while (!imem_req_valid && drain < 6) begin
            n_checks++;
            if (inst_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL drain_leak: got inst_valid=%b want 0",
                         inst_valid);
            end
            tick();
            drain++;
        end
        n_checks++;
        if (drain !== 2) begin
            n_fail++;
            $display("FAIL drain_cycles: got %0d want 2", drain);
        end
        n_checks++;
        if (imem_req_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL drain_next_addr: got %h want 100", imem_req_addr);
        end
        got = 0;
        for (int c = 0; c < 10 && !inst_valid; c++) tick();
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h100 ||
            instruction !== mem_word(32'h100)) begin
            n_fail++;
            $display("FAIL drain_first_inst: got v=%b pc=%h i=%h want pc=100",
                     inst_valid, inst_pc, instruction);
        end
    endtask

    task automatic test_redirect_collide();
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        auto_resp      = 1'b1;
        tick();
        tick();
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || pend.size() != 1) begin
            n_fail++;
            $display("FAIL collide_setup: got v=%b pc=%h pend=%0d",
                     inst_valid, inst_pc, pend.size());
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if (inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_flush: got inst_valid=%b want 0", inst_valid);
        end
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL collide_req: got v=%b a=%h want v=1 a=200",
                     imem_req_valid, imem_req_addr);
        end
        for (int c = 0; c < 10 && !inst_valid; c++) tick();
        n_checks++;
        if (inst_pc !== 32'h200 || instruction !== mem_word(32'h200)) begin
            n_fail++;
            $display("FAIL collide_first_inst: got pc=%h i=%h want pc=200",
                     inst_pc, instruction);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        imem_req_ready = 1'b1;
        auto_resp      = 1'b1;
        tick();
        tick();
        n_checks++;
        if (inst_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_setup: got inst_valid=%b want 1", inst_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async_rst: got inst_valid=%b want 0", inst_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        pend.delete();
        auto_resp       = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hBADB_AD00;
        tick();
        imem_resp_valid = 1'b0;
        n_checks++;
        if (inst_valid !== 1'b0 || imem_req_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_stray_resp: got v=%b a=%h want v=0 a=0",
                     inst_valid, imem_req_addr);
        end
        imem_req_ready = 1'b1;
        auto_resp      = 1'b1;
        for (int c = 0; c < 10 && !inst_valid; c++) tick();
        n_checks++;
        if (inst_pc !== 32'h0 || instruction !== mem_word(32'h0)) begin
            n_fail++;
            $display("FAIL mid_first_inst: got pc=%h i=%h want pc=0 i=%h",
                     inst_pc, instruction, mem_word(32'h0));
        end
    endtask

`ifdef FETCH_MISALIGN_CHECK_EN
    task automatic test_misalign();
        int bad;
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        auto_resp      = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if (fetch_misalign !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign_flag: got %b want 1", fetch_misalign);
        end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) bad++;
            tick();
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL misalign_blocked: got %0d active cycles want 0", bad);
        end
        do_reset();
        n_checks++;
        if (fetch_misalign !== 1'b0 || imem_req_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign_clear: got f=%b v=%b want f=0 v=1",
                     fetch_misalign, imem_req_valid);
        end
    endtask
`else
    task automatic test_misalign();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL align_redirect: got v=%b a=%h want v=1 a=100",
                     imem_req_valid, imem_req_addr);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_drain();
        test_redirect_collide();
        test_reset_midflight();
        test_misalign();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
